music_tone_audio_port: RTL and testbench



---
 rtl/music_tone_audio_port.sv | 127 ++++++++++++
 tb/tb_music_tone_audio_port.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/music_tone_audio_port.sv
// music_tone_audio_port: DDS note generator driving a PWM audio pin; define AUDIO_SQUARE_OUT_EN for a square-wave output instead of sine PWM
module music_tone_audio_port #(
    parameter int CLK_HZ = 100_000_000,
    parameter int ACC_W  = 32,
    parameter int PWM_W  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       SD,
    input  logic [4:0] tone,
    output logic       sd,
    output logic       audio_out
);
    localparam longint unsigned C_UHZ = 64'd523_251_131;
    localparam longint unsigned D_UHZ = 64'd587_329_536;
    localparam longint unsigned E_UHZ = 64'd659_255_114;
    localparam longint unsigned F_UHZ = 64'd698_456_463;
    localparam longint unsigned G_UHZ = 64'd783_990_872;
    localparam longint unsigned A_UHZ = 64'd880_000_000;
    localparam longint unsigned B_UHZ = 64'd987_766_603;

    // Fifth-octave pitch in micro-hertz, divided down by 2^sh, scaled to a rounded tuning word.
    function automatic logic [ACC_W-1:0] ftw_of(input longint unsigned f5_uhz, input int sh);
        longint unsigned div;
        div = (64'(CLK_HZ) * 64'd1_000_000) << sh;
        return ACC_W'(((f5_uhz << ACC_W) + (div >> 1)) / div);
    endfunction

    logic             sd_q, audio_q, audio_d, rest, mute;
    logic [4:0]       tone_q;
    logic [ACC_W-1:0] acc_q, acc_d, ftw;

    // Tuning word per note code; every arm folds to a constant.
    always_comb begin
        ftw = '0;
        case (tone_q)
            5'd1:  ftw = ftw_of(C_UHZ, 2);
            5'd2:  ftw = ftw_of(D_UHZ, 2);
            5'd3:  ftw = ftw_of(E_UHZ, 2);
            5'd4:  ftw = ftw_of(F_UHZ, 2);
            5'd5:  ftw = ftw_of(G_UHZ, 2);
            5'd6:  ftw = ftw_of(A_UHZ, 2);
            5'd7:  ftw = ftw_of(B_UHZ, 2);
            5'd8:  ftw = ftw_of(C_UHZ, 1);
            5'd9:  ftw = ftw_of(D_UHZ, 1);
            5'd10: ftw = ftw_of(E_UHZ, 1);
            5'd11: ftw = ftw_of(F_UHZ, 1);
            5'd12: ftw = ftw_of(G_UHZ, 1);
            5'd13: ftw = ftw_of(A_UHZ, 1);
            5'd14: ftw = ftw_of(B_UHZ, 1);
            5'd15: ftw = ftw_of(C_UHZ, 0);
            5'd16: ftw = ftw_of(D_UHZ, 0);
            5'd17: ftw = ftw_of(E_UHZ, 0);
            5'd18: ftw = ftw_of(F_UHZ, 0);
            5'd19: ftw = ftw_of(G_UHZ, 0);
            5'd20: ftw = ftw_of(A_UHZ, 0);
            5'd21: ftw = ftw_of(B_UHZ, 0);
            default: ftw = '0;
        endcase
    end

`ifndef AUDIO_SQUARE_OUT_EN
    localparam logic [7:0] QROM [64] = '{
        8'd128, 8'd131, 8'd134, 8'd137, 8'd140, 8'd143, 8'd146, 8'd149,
        8'd152, 8'd155, 8'd158, 8'd162, 8'd165, 8'd167, 8'd170, 8'd173,
        8'd176, 8'd179, 8'd182, 8'd185, 8'd188, 8'd190, 8'd193, 8'd196,
        8'd198, 8'd201, 8'd203, 8'd206, 8'd208, 8'd211, 8'd213, 8'd215,
        8'd218, 8'd220, 8'd222, 8'd224, 8'd226, 8'd228, 8'd230, 8'd232,
        8'd234, 8'd235, 8'd237, 8'd238, 8'd240, 8'd241, 8'd243, 8'd244,
        8'd245, 8'd246, 8'd248, 8'd249, 8'd250, 8'd250, 8'd251, 8'd252,
        8'd253, 8'd253, 8'd254, 8'd254, 8'd254, 8'd255, 8'd255, 8'd255
    };

    logic [7:0]       idx, base, sine;
    logic [5:0]       k;
    logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d, sample_q, sample_d;

    // Quarter-wave fold: mirror in odd quadrants, invert in the lower half; the
    // peak (idx 64/192) and the exact midpoint (idx 128) fall outside the ROM.
    always_comb begin
        idx  = acc_q[ACC_W-1 -: 8];
        k    = idx[6] ? 6'd0 - idx[5:0] : idx[5:0];
        base = (idx[6] && idx[5:0] == 6'd0) ? 8'd255 : QROM[k];
        sine = (idx == 8'd128) ? 8'd128 : idx[7] ? 8'd255 - base : base;
    end
`endif

    // Next state: phase accumulation, per-period sample latch and muted PWM compare.
    always_comb begin
        rest    = (tone_q == 5'd0) || (tone_q > 5'd21);
        mute    = rest || !SD;
        acc_d   = rest ? '0 : acc_q + ftw;
`ifdef AUDIO_SQUARE_OUT_EN
        audio_d = !mute && acc_q[ACC_W-1];
`else
        pwm_cnt_d = pwm_cnt_q + 1'b1;
        sample_d  = (pwm_cnt_q == '1) ? sine : sample_q;
        audio_d   = !mute && (pwm_cnt_q < sample_q);
`endif
    end

    // State registers, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sd_q      <= 1'b0;
            tone_q    <= '0;
            acc_q     <= '0;
            audio_q   <= 1'b0;
`ifndef AUDIO_SQUARE_OUT_EN
            sample_q  <= '0;
            pwm_cnt_q <= '0;
`endif
        end else begin
            sd_q      <= SD;
            tone_q    <= tone;
            acc_q     <= acc_d;
            audio_q   <= audio_d;
`ifndef AUDIO_SQUARE_OUT_EN
            sample_q  <= sample_d;
            pwm_cnt_q <= pwm_cnt_d;
`endif
        end
    end

    assign sd        = sd_q;
    assign audio_out = audio_q;
endmodule

// File: tb/tb_music_tone_audio_port.sv
// tb_music_tone_audio_port: pitch/sine model compared every cycle plus literal pins for the DDS audio port
module tb_music_tone_audio_port;
    logic        clk = 1'b0, rst_n = 1'b0, SD = 1'b1;
    logic [4:0]  tone = 5'd13;
    logic        sd, audio_out;
    int          n_checks = 0, n_err = 0;

    logic [4:0]  m_tone = '0;
    logic [31:0] m_acc = '0, m_phase, force_val = '0;
    logic [7:0]  m_cnt = '0, m_sample = '0;
    logic        m_sd = 1'b0, m_audio = 1'b0, force_on = 1'b0;

    music_tone_audio_port dut (
        .clk(clk), .rst_n(rst_n), .SD(SD), .tone(tone), .sd(sd), .audio_out(audio_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic bit is_rest(input logic [4:0] t);
        return t == 5'd0 || t > 5'd21;
    endfunction

    // Equal-temperament pitch of a diatonic note code, turned into a tuning word.
    function automatic logic [31:0] model_ftw(input logic [4:0] t);
        int  off [7];
        int  n, midi;
        real f;
        off = '{0, 2, 4, 5, 7, 9, 11};
        if (is_rest(t)) return 32'd0;
        n    = int'(t) - 1;
        midi = 48 + 12 * (n / 7) + off[n % 7];
        f    = 440.0 * $pow(2.0, (midi - 69) / 12.0);
        return 32'($rtoi($floor(f * 4294967296.0 / 1.0e8 + 0.5)));
    endfunction

    function automatic logic [7:0] model_sine(input int i);
        real s;
        s = $sin(2.0 * 3.141592653589793 * i / 256.0);
        return 8'($rtoi($floor(127.5 + 127.5 * s + 0.5)));
    endfunction

    assign m_phase = force_on ? force_val : m_acc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tone <= '0; m_acc <= '0; m_cnt <= '0; m_sample <= '0; m_sd <= 1'b0; m_audio <= 1'b0;
        end else begin
            m_sd     <= SD;
            m_tone   <= tone;
            m_acc    <= force_on ? force_val : is_rest(m_tone) ? 32'd0 : m_phase + model_ftw(m_tone);
            m_cnt    <= m_cnt + 8'd1;
            m_sample <= (m_cnt == 8'd255) ? model_sine(int'(m_phase[31:24])) : m_sample;
`ifdef AUDIO_SQUARE_OUT_EN
            m_audio  <= !(is_rest(m_tone) || !SD) && m_phase[31];
`else
            m_audio  <= !(is_rest(m_tone) || !SD) && (m_cnt < m_sample);
`endif
        end
    end

    always @(negedge clk) begin
        check("sd", 32'(sd), 32'(m_sd));
        check("audio_out", 32'(audio_out), 32'(m_audio));
        check("acc", dut.acc_q, m_acc);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        int seq [6];
        logic [31:0] fv [3];
        int ex [3];
        int highs, w;
        seq = '{12, 12, 12, 11, 10, 10};
        fv  = '{32'h4000_0000, 32'hC000_0000, 32'h0000_0000};
        ex  = '{255, 0, 128};
        step(3);
        check("reset_sd", 32'(sd), 0);
        check("reset_audio", 32'(audio_out), 0);
        check("reset_acc", dut.acc_q, 0);
        rst_n = 1'b1;
        step(1);
        check("sd_after_release", 32'(sd), 1);
        check("acc_before_first_step", dut.acc_q, 0);
        step(1);
        check("acc_A4_one_step", dut.acc_q, 32'd18898);
        step(8);
        check("acc_A4_nine_steps", dut.acc_q, 32'd170082);
        step(3000);
        tone = 5'd22;
        step(10000);
        check("rest22_acc", dut.acc_q, 0);
        check("rest22_audio", 32'(audio_out), 0);
        tone = 5'd0;
        step(10000);
        check("rest0_acc", dut.acc_q, 0);
        check("rest0_audio", 32'(audio_out), 0);
        tone = 5'd8;
        step(2);
        check("acc_C4_one_step", dut.acc_q, 32'd11237);
        tone = 5'd0;
        step(3);
        tone = 5'd20;
        step(2);
        check("acc_A5_one_step", dut.acc_q, 32'd37796);
        step(1);
        check("acc_A5_two_steps", dut.acc_q, 32'd75592);
        for (int i = 0; i < 6; i++) begin
            tone = 5'(seq[i]);
            step(2);
        end
        tone = 5'd13;
        step(600);
        SD = 1'b0;
        step(1);
        check("sd_low_audio", 32'(audio_out), 0);
        check("sd_low_sd", 32'(sd), 0);
        step(300);
        SD = 1'b1;
        step(10);
`ifndef AUDIO_SQUARE_OUT_EN
        for (int i = 0; i < 3; i++) begin
            force_val = fv[i];
            force_on  = 1'b1;
            force dut.acc_q = force_val;
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (m_cnt != 8'd0 && w < 300);
            highs = 0;
            repeat (256) begin
                @(negedge clk);
                highs += int'(audio_out);
            end
            check("pwm_duty_high_cycles", 32'(highs), 32'(ex[i]));
            #1;
            release dut.acc_q;
            force_on = 1'b0;
        end
`endif
        step(20);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its end, checks %0d errors %0d", n_checks, n_err);
        $fatal(1);
    end
endmodule
